ahbl_serial_loader: RTL and testbench
=====================================

Name: ahbl_serial_loader

Overview:
- UART-driven AHB-Lite bus master for bring-up and loading.
- Receives framed commands on a serial RX pin and turns them into single-word AHB-Lite write transfers, e.g. to preload SRAM0/SRAM1 before the CPU runs.
- Drives a CPU hold signal so software can be loaded, then released by a serial command.
- Sits as an extra master on the AHB-Lite crossbar, alongside the CPU.

Parameters:
- W_ADDR, 32, AHB address width.
- W_DATA, 32, AHB data width (only 32 supported).
- CLK_DIV, 16, clk cycles per UART bit; must be ≥ 4 and even.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous UART input, 8N1, idle high.
- ahblm_hready  input  1  AHB-Lite HREADY.
- ahblm_hresp  input  1  AHB-Lite HRESP (1 = ERROR).
- ahblm_haddr  output  W_ADDR  transfer address.
- ahblm_hwrite  output  1  always 1 when HTRANS is NONSEQ.
- ahblm_htrans  output  2  IDLE (2'b00) or NONSEQ (2'b10) only.
- ahblm_hsize  output  3  constant 3'b010.
- ahblm_hburst  output  3  constant 3'b000.
- ahblm_hprot  output  4  constant 4'b0011.
- ahblm_hmastlock  output  1  constant 0.
- ahblm_hwdata  output  W_DATA  write data.
- ahblm_hrdata  input  W_DATA  unused.
- cpu_hold  output  1  1 = CPU held; top level ORs this into CPU reset.
- err  output  1  sticky error flag; cleared only by rst.

Behaviour:
- Clock and reset: single clock; rst is synchronous and active-high.
- Reset values:
  - htrans = IDLE, haddr = 0, hwdata = 0.
  - cpu_hold = 1, err = 0.
  - RX synchroniser flops = 1.
  - Receiver in IDLE, parser in CMD, byte buffer empty.
  - An rst assertion mid-frame or mid-transfer aborts everything immediately. The master does not wait for hready.
- Synchroniser: rx passes through 2 flops before use; rxs is the synchronised value.
- Receiver FSM:
  - IDLE: a 1→0 transition on rxs moves to START.
  - START: count CLK_DIV/2 cycles, then sample rxs. If 1, it was a false start; return to IDLE with no error. If 0, go to DATA.
  - DATA: sample every CLK_DIV cycles, 8 samples, LSB first.
  - STOP: sample after a further CLK_DIV cycles.
    - Stop bit = 1: one-cycle byte strobe.
    - Stop bit = 0: framing error. Set err, discard the byte, force parser to CMD.
  - Return to IDLE in both cases.
- Byte buffer (one entry):
  - The strobe loads the buffer.
  - If the buffer is already full, this is an overrun: set err and drop the new byte; the buffer keeps the old byte.
  - The parser consumes the buffer only in CMD, ADDR or DATA states; consumption empties it the same cycle.
  - A strobe in the same cycle as a consume is accepted, not an overrun.
- Parser FSM:
  - CMD:
    - 0x57 ('W'): go to ADDR.
    - 0x47 ('G'): cpu_hold ← 0 next cycle.
    - 0x48 ('H'): cpu_hold ← 1 next cycle.
    - Any other byte: ignored silently, stay in CMD.
  - ADDR: 4 bytes, little-endian, into an address shift register. haddr[1:0] is forced to 0.
  - DATA: 4 bytes, little-endian, into a data register. After the 4th byte go to BUS_A.
  - BUS_A: drive htrans = NONSEQ, hwrite = 1, haddr = assembled address. Hold all of these until hready = 1 is sampled, then go to BUS_D.
  - BUS_D: htrans = IDLE; hwdata = assembled data, held until hready = 1.
    - If hresp = 1 in that cycle, set err.
    - Return to CMD.
- Bus-side values:
  - haddr keeps its last value while IDLE.
  - At most one transfer is outstanding.
  - A write costs ≥ 2 bus cycles.
- Latency: the NONSEQ address phase is driven 2 cycles after the strobe of the final data byte (1 cycle buffer, 1 cycle parser).
- Throughput: at CLK_DIV = 16 a byte takes 160 cycles. Overrun can only occur if the bus stalls longer than one byte time while the buffer is full.

Test Plan:
- Write: CLK_DIV = 16, send 57 00 00 08 20 EF BE AD DE with hready = 1 → exactly one NONSEQ write, haddr = 0x20080000, hsize = 010, next cycle hwdata = 0xDEADBEEF; err = 0; htrans IDLE otherwise.
- Stall: same write with hready held 0 for 5 cycles during the address phase → haddr/htrans stable all 5 cycles; single transfer completes; no duplicate NONSEQ.
- Hold control and unknown command: send 47 → cpu_hold falls to 0; send 48 → cpu_hold = 1; send 0x00 → no bus activity, err = 0.
- Error response: slave returns two-cycle ERROR in data phase (hready = 0, hresp = 1; then hready = 1, hresp = 1) → err = 1 and stays 1 through further good writes until rst.
- Receiver robustness:
  - rx low pulse of 4 cycles → no byte, err = 0.
  - Byte 57 with stop bit 0 → err = 1, parser in CMD; a following full good write frame completes correctly.
- Reset mid-operation: assert rst during the 3rd address byte, then send a full write frame → only the post-reset write appears on the bus; cpu_hold = 1, err = 0 after reset.

Source files
------------

// File: rtl/ahbl_serial_loader_if.sv
// AHB-Lite master-side bus bundle for the serial loader.
// The master modport is what the loader drives; the slave modport is the fabric/slave view.
interface ahbl_if #(
  parameter int unsigned W_ADDR = 32,
  parameter int unsigned W_DATA = 32
);
  logic              hready;
  logic              hresp;
  logic [W_ADDR-1:0] haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic              hmastlock;
  logic [W_DATA-1:0] hwdata;
  logic [W_DATA-1:0] hrdata;

  modport master (
    input  hready, hresp, hrdata,
    output haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata
  );

  modport slave (
    output hready, hresp, hrdata,
    input  haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata
  );
endinterface

// File: rtl/ahbl_serial_loader.sv
// UART (8N1) command receiver that issues single-word AHB-Lite writes and
// controls a CPU hold line; 'W' + 4 addr + 4 data bytes (LE), 'G' release, 'H' hold.
module ahbl_serial_loader #(
  parameter int unsigned W_ADDR  = 32,
  parameter int unsigned W_DATA  = 32,
  parameter int unsigned CLK_DIV = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  ahbl_if.master      ahblm,
  output logic        cpu_hold,
  output logic        err
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_CMD, P_ADDR, P_DATA, P_BUS_A, P_BUS_D} p_state_t;

  // ---------------- receiver ----------------
  logic            rx_m, rxs, rxs_q;
  rx_state_t       rx_state, rx_state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bitc, bitc_n;
  logic [7:0]      sh, sh_n;
  logic            stb, stb_n;
  logic            ferr, ferr_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m     <= 1'b1;
      rxs      <= 1'b1;
      rxs_q    <= 1'b1;
      rx_state <= RX_IDLE;
      cnt      <= '0;
      bitc     <= '0;
      sh       <= '0;
      stb      <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      rx_m     <= rx;
      rxs      <= rx_m;
      rxs_q    <= rxs;
      rx_state <= rx_state_n;
      cnt      <= cnt_n;
      bitc     <= bitc_n;
      sh       <= sh_n;
      stb      <= stb_n;
      ferr     <= ferr_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    cnt_n      = cnt + 1'b1;
    bitc_n     = bitc;
    sh_n       = sh;
    stb_n      = 1'b0;
    ferr_n     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        cnt_n = '0;
        if (rxs_q && !rxs) rx_state_n = RX_START;
      end
      RX_START: begin
        if (cnt == CW'(CLK_DIV/2 - 1)) begin
          cnt_n      = '0;
          bitc_n     = '0;
          rx_state_n = rxs ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == CW'(CLK_DIV - 1)) begin
          cnt_n  = '0;
          sh_n   = {rxs, sh[7:1]};
          bitc_n = bitc + 1'b1;
          if (bitc == 3'd7) rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == CW'(CLK_DIV - 1)) begin
          cnt_n      = '0;
          rx_state_n = RX_IDLE;
          if (rxs) stb_n  = 1'b1;
          else     ferr_n = 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- byte buffer + parser ----------------
  p_state_t          p_state, p_state_n;
  logic [1:0]        bcnt, bcnt_n;
  logic              buf_full, buf_full_n;
  logic [7:0]        buf_data, buf_data_n;
  logic [31:0]       addr_sr, addr_sr_n;
  logic [31:0]       data_sr, data_sr_n;
  logic [W_ADDR-1:0] haddr_q, haddr_n;
  logic [W_DATA-1:0] hwdata_q, hwdata_n;
  logic              hold_n, err_n;
  logic              consume;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_state  <= P_CMD;
      bcnt     <= '0;
      buf_full <= 1'b0;
      buf_data <= '0;
      addr_sr  <= '0;
      data_sr  <= '0;
      haddr_q  <= '0;
      hwdata_q <= '0;
      cpu_hold <= 1'b1;
      err      <= 1'b0;
    end else begin
      p_state  <= p_state_n;
      bcnt     <= bcnt_n;
      buf_full <= buf_full_n;
      buf_data <= buf_data_n;
      addr_sr  <= addr_sr_n;
      data_sr  <= data_sr_n;
      haddr_q  <= haddr_n;
      hwdata_q <= hwdata_n;
      cpu_hold <= hold_n;
      err      <= err_n;
    end
  end

  always_comb begin
    p_state_n  = p_state;
    bcnt_n     = bcnt;
    buf_data_n = buf_data;
    addr_sr_n  = addr_sr;
    data_sr_n  = data_sr;
    haddr_n    = haddr_q;
    hwdata_n   = hwdata_q;
    hold_n     = cpu_hold;
    err_n      = err;

    consume    = buf_full && (p_state == P_CMD || p_state == P_ADDR || p_state == P_DATA);
    buf_full_n = buf_full && !consume;

    // A strobe coinciding with a consume refills the just-emptied slot.
    if (stb) begin
      if (buf_full && !consume) begin
        err_n = 1'b1;
      end else begin
        buf_full_n = 1'b1;
        buf_data_n = sh;
      end
    end
    if (ferr) err_n = 1'b1;

    case (p_state)
      P_CMD: begin
        if (consume) begin
          case (buf_data)
            8'h57:   begin p_state_n = P_ADDR; bcnt_n = '0; end
            8'h47:   hold_n = 1'b0;
            8'h48:   hold_n = 1'b1;
            default: ;
          endcase
        end
      end
      P_ADDR: begin
        if (consume) begin
          addr_sr_n = {buf_data, addr_sr[31:8]};
          bcnt_n    = bcnt + 1'b1;
          if (bcnt == 2'd3) p_state_n = P_DATA;
        end
      end
      P_DATA: begin
        if (consume) begin
          data_sr_n = {buf_data, data_sr[31:8]};
          bcnt_n    = bcnt + 1'b1;
          if (bcnt == 2'd3) begin
            p_state_n = P_BUS_A;
            haddr_n   = W_ADDR'({addr_sr[31:2], 2'b00});
          end
        end
      end
      P_BUS_A: begin
        if (ahblm.hready) begin
          p_state_n = P_BUS_D;
          hwdata_n  = W_DATA'(data_sr);
        end
      end
      P_BUS_D: begin
        if (ahblm.hresp) err_n = 1'b1;
        if (ahblm.hready) p_state_n = P_CMD;
      end
      default: p_state_n = P_CMD;
    endcase

    // Framing errors resync the parser, but an in-flight bus transfer is
    // allowed to finish so the AHB protocol is never violated.
    if (ferr && (p_state == P_ADDR || p_state == P_DATA)) p_state_n = P_CMD;
  end

  assign ahblm.htrans    = (p_state == P_BUS_A) ? 2'b10 : 2'b00;
  assign ahblm.hwrite    = 1'b1;
  assign ahblm.haddr     = haddr_q;
  assign ahblm.hwdata    = hwdata_q;
  assign ahblm.hsize     = 3'b010;
  assign ahblm.hburst    = 3'b000;
  assign ahblm.hprot     = 4'b0011;
  assign ahblm.hmastlock = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{ahblm.hrdata, addr_sr[1:0]};

endmodule

// File: tb/tb_ahbl_serial_loader.sv
// Randomized scoreboard bench for ahbl_serial_loader: serial frames in,
// expected AHB writes queued and matched by an independent bus monitor.
module tb_ahbl_serial_loader;
  localparam int unsigned CLK_DIV = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic cpu_hold, err;

  ahbl_if #(.W_ADDR(32), .W_DATA(32)) bus ();

  ahbl_serial_loader #(.W_ADDR(32), .W_DATA(32), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .rx(rx), .ahblm(bus), .cpu_hold(cpu_hold), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
  } xfer_t;

  xfer_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int stall_addr = 0;
  bit err_mode = 1'b0;
  logic exp_hold = 1'b1;
  logic exp_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- bus slave ----------------
  bit dphase = 1'b0;
  int dcnt = 0;
  int await_cnt = 0;
  initial begin
    bus.hready = 1'b1;
    bus.hresp  = 1'b0;
    bus.hrdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        bus.hready = 1'b1; bus.hresp = 1'b0; dphase = 1'b0; await_cnt = 0;
      end else if (dphase) begin
        if (err_mode && dcnt == 0) begin
          bus.hready = 1'b0; bus.hresp = 1'b1; dcnt = 1;
        end else begin
          bus.hready = 1'b1; bus.hresp = err_mode; dphase = 1'b0;
        end
      end else if (bus.htrans == 2'b10) begin
        bus.hresp = 1'b0;
        if (await_cnt < stall_addr) begin
          bus.hready = 1'b0; await_cnt++;
        end else begin
          bus.hready = 1'b1; await_cnt = 0; dphase = 1'b1; dcnt = 0;
        end
      end else begin
        bus.hready = 1'b1; bus.hresp = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  bit a_done = 1'b0;
  int ns = 0;
  always @(negedge clk) begin
    if (rst) begin
      a_done = 1'b0; ns = 0;
    end else if (bus.htrans == 2'b10) begin
      ns++;
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL spurious_nonseq: haddr %h while no write expected", bus.haddr);
      end else begin
        check("haddr", 64'(bus.haddr), 64'(exp_q[0].addr));
        check("ctrl", {53'd0, bus.hwrite, bus.hsize, bus.hburst, bus.hprot, bus.hmastlock},
                      {53'd0, 1'b1, 3'b010, 3'b000, 4'b0011, 1'b0});
        if (bus.hready) begin
          check("nonseq_cycles", 64'(ns), 64'(exp_q[0].stall + 1));
          ns = 0; a_done = 1'b1;
        end
      end
    end else if (a_done && bus.hready) begin
      check("hwdata", 64'(bus.hwdata), 64'(exp_q[0].data));
      check("htrans_dphase", 64'(bus.htrans), 64'd0);
      void'(exp_q.pop_front());
      a_done = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) rx = 1'b0;
    repeat (CLK_DIV - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) rx = b[i];
      repeat (CLK_DIV - 1) @(negedge clk);
    end
    @(negedge clk) rx = stop;
    repeat (CLK_DIV - 1) @(negedge clk);
    @(negedge clk) rx = 1'b1;
    repeat (CLK_DIV - 1) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk); n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_timeout: %0d writes still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic send_write(input logic [31:0] addr, input logic [31:0] data, input int stall);
    xfer_t x;
    x.addr = addr & 32'hFFFF_FFFC;
    x.data = data;
    x.stall = stall;
    stall_addr = stall;
    exp_q.push_back(x);
    send_byte(8'h57, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], 1'b1);
    for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8], 1'b1);
    drain("write");
  endtask

  task automatic check_status(input string tag);
    check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'(exp_hold));
    check({tag, "_err"}, 64'(err), 64'(exp_err));
  endtask

  task automatic pulse_rst();
    @(negedge clk) rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_hold = 1'b1; exp_err = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_htrans", 64'(bus.htrans), 64'd0);
    check("reset_haddr", 64'(bus.haddr), 64'd0);
    check("reset_hwdata", 64'(bus.hwdata), 64'd0);
    check_status("reset");

    send_write(32'h2008_0000, 32'hDEAD_BEEF, 0);
    check_status("write");
    send_write(32'h1000_0413, 32'h0123_4567, 5);
    check_status("stall");

    send_byte(8'h47, 1'b1); exp_hold = 1'b0; check_status("go");
    send_byte(8'h48, 1'b1); exp_hold = 1'b1; check_status("hold");
    send_byte(8'h00, 1'b1); check_status("unknown");

    for (int k = 0; k < 10; k++) begin
      case ($urandom_range(0, 3))
        0, 1: send_write($urandom, $urandom, int'($urandom_range(0, 6)));
        2: begin
          do b = 8'($urandom); while (b == 8'h57 || b == 8'h47 || b == 8'h48);
          send_byte(b, 1'b1);
        end
        default: begin
          if ($urandom_range(0, 1) == 1) begin send_byte(8'h47, 1'b1); exp_hold = 1'b0; end
          else begin send_byte(8'h48, 1'b1); exp_hold = 1'b1; end
        end
      endcase
      check_status("random");
    end

    @(negedge clk) rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CLK_DIV) @(negedge clk);
    check_status("false_start");

    send_byte(8'h57, 1'b0); exp_err = 1'b1;
    check_status("framing");
    send_write(32'hA5A5_0004, 32'hCAFE_F00D, 1);
    check_status("after_framing");

    pulse_rst();
    check_status("rst_clear");

    err_mode = 1'b1;
    send_write(32'h3000_0010, 32'h1111_2222, 0);
    err_mode = 1'b0;
    exp_err = 1'b1;
    check_status("hresp_err");
    send_write(32'h3000_0014, 32'h3333_4444, 2);
    check_status("err_sticky");

    send_byte(8'h47, 1'b1); exp_hold = 1'b0;
    send_byte(8'h57, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    @(negedge clk) rx = 1'b0;
    repeat (3 * CLK_DIV) @(negedge clk);
    pulse_rst();
    check_status("mid_rst");
    send_write(32'h0000_1238, 32'h5566_7788, 0);
    check_status("post_rst");

    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
